// File: rtl/switch_pkg.sv
// Shared types and constants for the egress scatter-gather DMA.
// Holds address/length widths, the header N-1 field and the FSM states.
package switch_pkg;

  localparam int ADDR_W     = 12;
  localparam int LEN_W      = 4;
  localparam int NW_W       = 12;
  localparam int HDR_NW_MSB = 11;
  localparam int HDR_NW_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FREE,
    DRAIN
  } state_e;

  // Word count minus one carried in the packet header word.
  function automatic logic [NW_W-1:0] hdr_nwords_m1(
    input logic [31:0] w
  );
    return w[HDR_NW_MSB:HDR_NW_LSB];
  endfunction

endpackage

// File: rtl/pack_out_fifo.sv
// Output FIFO of {sop, eop, data} entries with an occupancy count.
// Ports: i_push/i_wdata write, i_pop reads when o_vld, o_count = entries.
module pack_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_vld,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  assign o_vld   = (r_cnt != '0);
  assign w_pop   = o_vld & i_pop;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push)
        r_wp <= (r_wp == LAST) ? '0 : r_wp + AW'(1);
      if (w_pop)
        r_rp <= (r_rp == LAST) ? '0 : r_rp + AW'(1);
      if (i_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!i_push && w_pop)
        r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pack_sg_dma.sv
// Egress scatter-gather read DMA: walks a block list, reads MMU words,
// streams sop/eop/data to Tx and releases each block.
// Ports: tag in (iPktTag*), link SRAM (oLaddr*/iLdata), MMU read
// (oMmuRd*/iMmu*), Tx stream (oTx*/iTxRdy), block release (oFree*/iFreeRdy).
module pack_sg_dma
  import switch_pkg::*;
#(
  parameter int BLK_WORDS   = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iPktTagVld,
  input  logic [ADDR_W-1:0]                    iPktFirAddr,
  input  logic [LEN_W-1:0]                     iPktLen,
  output logic                                 oPktTagRdy,
  output logic [ADDR_W-1:0]                    oLaddr,
  output logic                                 oLaddrVld,
  input  logic [ADDR_W-1:0]                    iLdata,
  output logic [ADDR_W+$clog2(BLK_WORDS)-1:0]  oMmuRdAddr,
  output logic                                 oMmuRdVld,
  input  logic                                 iMmuRdRdy,
  input  logic [31:0]                          iMmuData,
  input  logic                                 iMmuDataVld,
  output logic [31:0]                          oTxData,
  output logic                                 oTxVld,
  output logic                                 oTxSop,
  output logic                                 oTxEop,
  input  logic                                 iTxRdy,
  output logic [ADDR_W-1:0]                    oFreeAddr,
  output logic                                 oFreeVld,
  input  logic                                 iFreeRdy
);

  localparam int OFS_W = $clog2(BLK_WORDS);
  localparam int CW    = $clog2(OFIFO_DEPTH+1);
  localparam logic [CW:0] CREDITS = (CW+1)'(OFIFO_DEPTH);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cur_blk;
  logic [ADDR_W-1:0] r_nxt_blk;
  logic [LEN_W-1:0]  r_blk_left;
  logic [NW_W-1:0]   r_idx;
  logic [NW_W-1:0]   r_nm1;
  logic              r_hdr_ok;
  logic              r_data_done;
  logic              r_lvld;
  logic              r_lcap;
  logic              r_inflight;
  logic              r_rd_sop;
  logic              r_rd_eop;
  logic              rLenErr;

  logic          w_on;
  logic          w_credit;
  logic          w_blk_end;
  logic          w_pkt_end;
  logic          w_force;
  logic          w_hdr_short;
  logic          w_req;
  logic          w_acc;
  logic          w_push;
  logic          w_links_idle;
  logic [33:0]   w_fifo_in;
  logic [33:0]   w_fifo_out;
  logic          w_fifo_vld;
  logic [CW-1:0] w_count;

  assign w_credit  = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < CREDITS;
  assign w_blk_end = &r_idx[OFS_W-1:0];
  assign w_pkt_end = r_hdr_ok && (r_idx == r_nm1);
  // Last block ran out before N words: end the packet here.
  assign w_force   = w_blk_end && (r_blk_left == '0) && !w_pkt_end;
  // Only word 0 precedes the header, so this means N=1 already sent.
  assign w_hdr_short  = r_hdr_ok && (r_idx > r_nm1);
  assign w_req     = (r_state == READ) && w_credit &&
                     ((r_idx == '0) || r_hdr_ok) && !w_hdr_short;
  assign w_acc     = w_req && iMmuRdRdy;
  // Data with nothing in flight is a leftover from before a reset.
  assign w_push    = iMmuDataVld && r_inflight;
  assign w_links_idle = !r_lvld && !r_lcap;

  // Word 0's eop is only known once its own header arrives.
  assign w_fifo_in = {r_rd_sop,
                      r_rd_sop ? (hdr_nwords_m1(iMmuData) == '0) : r_rd_eop,
                      iMmuData};

  pack_out_fifo #(
    .DEPTH (OFIFO_DEPTH),
    .W     (34)
  ) u_fifo (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_push  (w_push),
    .i_wdata (w_fifo_in),
    .i_pop   (iTxRdy),
    .o_rdata (w_fifo_out),
    .o_vld   (w_fifo_vld),
    .o_count (w_count)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= IDLE;
      r_cur_blk   <= '0;
      r_nxt_blk   <= '0;
      r_blk_left  <= '0;
      r_idx       <= '0;
      r_nm1       <= '0;
      r_hdr_ok    <= 1'b0;
      r_data_done <= 1'b0;
      r_lvld      <= 1'b0;
      r_lcap      <= 1'b0;
      r_inflight  <= 1'b0;
      r_rd_sop    <= 1'b0;
      r_rd_eop    <= 1'b0;
      rLenErr     <= 1'b0;
    end else begin
      r_lvld <= 1'b0;
      r_lcap <= r_lvld;
      if (r_lcap) r_nxt_blk <= iLdata;
      if (w_acc)
        r_inflight <= 1'b1;
      else if (w_push)
        r_inflight <= 1'b0;
      if (w_acc) begin
        r_idx    <= r_idx + NW_W'(1);
        r_rd_sop <= (r_idx == '0);
        r_rd_eop <= w_pkt_end | w_force;
        if (w_force) rLenErr <= 1'b1;
      end
      if (w_push && r_rd_sop) begin
        r_nm1    <= hdr_nwords_m1(iMmuData);
        r_hdr_ok <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (iPktTagVld) begin
            r_cur_blk   <= iPktFirAddr;
            r_blk_left  <= iPktLen;
            r_idx       <= '0;
            r_hdr_ok    <= 1'b0;
            r_data_done <= 1'b0;
            r_lvld      <= (iPktLen != '0);
            r_state     <= READ;
          end
        end
        READ: begin
          if (w_acc && (w_blk_end || w_pkt_end)) begin
            r_data_done <= w_pkt_end | w_force;
            r_state     <= FREE;
          end else if (w_hdr_short && w_links_idle) begin
            r_data_done <= 1'b1;
            r_state     <= FREE;
          end
        end
        FREE: begin
          if (iFreeRdy) begin
            if (r_blk_left == '0) begin
              r_state <= IDLE;
            end else begin
              r_cur_blk  <= r_nxt_blk;
              r_blk_left <= r_blk_left - LEN_W'(1);
              r_lvld     <= (r_blk_left != LEN_W'(1));
              r_state    <= r_data_done ? DRAIN : READ;
            end
          end
        end
        DRAIN: begin
          if (w_links_idle) r_state <= FREE;
        end
      endcase
    end
  end

  assign w_on       = !iRst;
  assign oPktTagRdy = w_on && (r_state == IDLE);
  assign oLaddr     = w_on ? r_cur_blk : '0;
  assign oLaddrVld  = w_on && r_lvld;
  assign oMmuRdAddr = w_on ? {r_cur_blk, r_idx[OFS_W-1:0]} : '0;
  assign oMmuRdVld  = w_on && w_req;
  assign oTxData    = w_on ? w_fifo_out[31:0] : '0;
  assign oTxSop     = w_on && w_fifo_vld && w_fifo_out[33];
  assign oTxEop     = w_on && w_fifo_vld && w_fifo_out[32];
  assign oTxVld     = w_on && w_fifo_vld;
  assign oFreeAddr  = w_on ? r_cur_blk : '0;
  assign oFreeVld   = w_on && (r_state == FREE);

endmodule

// File: tb/tb_pack_sg_dma.sv
// Randomized bench for pack_sg_dma against a packet-level reference.
// Models link SRAM and MMU; expects word, release and link sequences.
module tb_pack_sg_dma;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iPktTagVld;
  logic [11:0] iPktFirAddr;
  logic [3:0]  iPktLen;
  logic        oPktTagRdy;
  logic [11:0] oLaddr;
  logic        oLaddrVld;
  logic [11:0] iLdata;
  logic [15:0] oMmuRdAddr;
  logic        oMmuRdVld;
  logic        iMmuRdRdy;
  logic [31:0] iMmuData;
  logic        iMmuDataVld;
  logic [31:0] oTxData;
  logic        oTxVld;
  logic        oTxSop;
  logic        oTxEop;
  logic        iTxRdy;
  logic [11:0] oFreeAddr;
  logic        oFreeVld;
  logic        iFreeRdy;

  always #5 iClk = ~iClk;

  pack_sg_dma #(
    .BLK_WORDS   (16),
    .OFIFO_DEPTH (4)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iPktTagVld  (iPktTagVld),
    .iPktFirAddr (iPktFirAddr),
    .iPktLen     (iPktLen),
    .oPktTagRdy  (oPktTagRdy),
    .oLaddr      (oLaddr),
    .oLaddrVld   (oLaddrVld),
    .iLdata      (iLdata),
    .oMmuRdAddr  (oMmuRdAddr),
    .oMmuRdVld   (oMmuRdVld),
    .iMmuRdRdy   (iMmuRdRdy),
    .iMmuData    (iMmuData),
    .iMmuDataVld (iMmuDataVld),
    .oTxData     (oTxData),
    .oTxVld      (oTxVld),
    .oTxSop      (oTxSop),
    .oTxEop      (oTxEop),
    .iTxRdy      (iTxRdy),
    .oFreeAddr   (oFreeAddr),
    .oFreeVld    (oFreeVld),
    .iFreeRdy    (iFreeRdy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [11:0] link_mem [4096];
  logic [11:0] chain [16];
  logic [15:0] hdr_addr;
  logic [31:0] hdr_word;

  logic [15:0] exp_rd[$];
  logic [33:0] exp_tx[$];
  logic [11:0] exp_free[$];
  logic [11:0] exp_lk[$];

  int n_extra = 0;
  int hold_err;
  int n_acc;
  int n_tx;
  int max_out;
  int tag_cyc = -10;
  int first_tx_cyc;
  bit bp_mode;
  bit exp_lenerr = 1'b0;
  int cur_len;

  logic        prev_fvld = 0, prev_frdy = 0;
  logic        prev_mvld = 0, prev_mrdy = 0;
  logic        prev_tvld = 0, prev_trdy = 0;
  logic [11:0] prev_faddr;
  logic [15:0] prev_maddr;
  logic [33:0] prev_tx;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == hdr_addr) return hdr_word;
    return ({16'h0, a} * 32'h9E3779B1) ^ 32'hA5C30000;
  endfunction

  function automatic logic any_out();
    return |{oPktTagRdy, oLaddr, oLaddrVld, oMmuRdAddr, oMmuRdVld,
             oTxData, oTxVld, oTxSop, oTxEop, oFreeAddr, oFreeVld};
  endfunction

  task automatic step();
    logic        acc, lk, tagh;
    logic [15:0] ra;
    logic [11:0] la;
    int          outst;
    @(negedge iClk);
    cyc++;
    tagh = iPktTagVld && oPktTagRdy;
    if (tagh) tag_cyc = cyc;
    if (cyc == tag_cyc + 1) begin
      chk("rd_t1", oMmuRdVld, 1'b1);
      chk("lk_t1", oLaddrVld, cur_len != 0);
    end
    acc = oMmuRdVld && iMmuRdRdy;
    ra  = oMmuRdAddr;
    if (acc) begin
      n_acc++;
      if (exp_rd.size() == 0) n_extra++;
      else chk("rd_addr", ra, exp_rd.pop_front());
    end
    lk = oLaddrVld;
    la = oLaddr;
    if (lk) begin
      if (exp_lk.size() == 0) n_extra++;
      else chk("lk_addr", la, exp_lk.pop_front());
    end
    if (oTxVld && first_tx_cyc < 0) first_tx_cyc = cyc;
    if (oTxVld && iTxRdy) begin
      n_tx++;
      if (exp_tx.size() == 0) n_extra++;
      else chk("tx_word", {oTxSop, oTxEop, oTxData}, exp_tx.pop_front());
    end
    if (oFreeVld && iFreeRdy) begin
      if (exp_free.size() == 0) n_extra++;
      else chk("free_addr", oFreeAddr, exp_free.pop_front());
    end
    outst = n_acc - n_tx;
    if (outst > max_out) max_out = outst;
    if (prev_fvld && !prev_frdy && !(oFreeVld && oFreeAddr == prev_faddr))
      hold_err++;
    if (prev_mvld && !prev_mrdy && !(oMmuRdVld && oMmuRdAddr == prev_maddr))
      hold_err++;
    if (prev_tvld && !prev_trdy &&
        !(oTxVld && {oTxSop, oTxEop, oTxData} == prev_tx))
      hold_err++;
    prev_fvld = oFreeVld;  prev_frdy = iFreeRdy;  prev_faddr = oFreeAddr;
    prev_mvld = oMmuRdVld; prev_mrdy = iMmuRdRdy; prev_maddr = oMmuRdAddr;
    prev_tvld = oTxVld;    prev_trdy = iTxRdy;
    prev_tx   = {oTxSop, oTxEop, oTxData};
    @(posedge iClk);
    #1;
    iMmuDataVld = acc;
    iMmuData    = acc ? mem_word(ra) : $urandom();
    iLdata      = lk ? link_mem[la] : 12'($urandom());
    if (tagh) iPktTagVld = 1'b0;
    if (bp_mode) begin
      iTxRdy    = (cyc % 3 == 0);
      iMmuRdRdy = !(cyc >= tag_cyc + 4 && cyc < tag_cyc + 9);
      iFreeRdy  = 1'($urandom_range(0, 1));
    end else begin
      iTxRdy    = 1'b1;
      iMmuRdRdy = 1'b1;
      iFreeRdy  = 1'b1;
    end
  endtask

  task automatic rand_chain(input int len);
    bit dup;
    for (int i = 0; i <= len; i++) begin
      do begin
        chain[i] = 12'($urandom());
        dup = 1'b0;
        for (int j = 0; j < i; j++)
          if (chain[j] == chain[i]) dup = 1'b1;
      end while (dup);
    end
  endtask

  task automatic run_pkt(input int len, input int n, input bit bp,
                         input int rst_at);
    int          cap, eff;
    logic [15:0] a;
    bit          done;
    cap = (len + 1) * 16;
    eff = (n < cap) ? n : cap;
    for (int i = 0; i < len; i++) link_mem[chain[i]] = chain[i+1];
    hdr_addr = {chain[0], 4'h0};
    hdr_word = {20'($urandom()), 12'(n - 1)};
    for (int k = 0; k < eff; k++) begin
      a = {chain[k/16], 4'(k % 16)};
      exp_rd.push_back(a);
      exp_tx.push_back({k == 0, k == eff - 1, mem_word(a)});
    end
    for (int i = 0; i <= len; i++) exp_free.push_back(chain[i]);
    for (int i = 0; i < len; i++) exp_lk.push_back(chain[i]);
    if (n > cap) exp_lenerr = 1'b1;
    hold_err = 0; n_acc = 0; n_tx = 0; max_out = 0;
    first_tx_cyc = -1; bp_mode = bp; cur_len = len;
    iPktFirAddr = chain[0];
    iPktLen     = 4'(len);
    iPktTagVld  = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      done = (exp_free.size() == 0) && (exp_tx.size() == 0);
      if (rst_at >= 0 && n_tx >= rst_at) break;
    end
    if (rst_at >= 0) begin
      chk("rst_reached", n_tx, rst_at);
      iRst = 1'b1;
      iPktTagVld = 1'b0;
      @(negedge iClk);
      chk("rst_out_now", any_out(), 1'b0);
      @(posedge iClk);
      #1;
      @(negedge iClk);
      chk("rst_out_next", any_out(), 1'b0);
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      iMmuDataVld = 1'b0;
      exp_rd.delete(); exp_tx.delete(); exp_free.delete(); exp_lk.delete();
      exp_lenerr = 1'b0;
      prev_fvld = 0; prev_mvld = 0; prev_tvld = 0;
      n_extra = 0;
      step();
      chk("rst_tag_rdy", oPktTagRdy, 1'b1);
      repeat (20) step();
      chk("rst_quiet", n_extra, 0);
      chk("rst_lenerr", dut.rLenErr, 1'b0);
      return;
    end
    chk("done", done, 1'b1);
    chk("rd_left", exp_rd.size(), 0);
    chk("lk_left", exp_lk.size(), 0);
    chk("extra", n_extra, 0);
    chk("hold", hold_err, 0);
    chk("over_credit", max_out > 4, 1'b0);
    if (!bp) chk("tx_lat", first_tx_cyc - tag_cyc, 3);
    chk("lenerr", dut.rLenErr, exp_lenerr);
    step();
    step();
    chk("tag_rdy", oPktTagRdy, 1'b1);
  endtask

  initial begin
    int len, n;
    for (int i = 0; i < 4096; i++) link_mem[i] = 12'h000;
    hdr_addr = 16'hFFFF;
    hdr_word = 32'h0;
    iRst = 1'b1;
    iPktTagVld = 1'b0; iPktFirAddr = '0; iPktLen = '0;
    iLdata = '0; iMmuRdRdy = 1'b1; iMmuData = '0; iMmuDataVld = 1'b0;
    iTxRdy = 1'b1; iFreeRdy = 1'b1;
    bp_mode = 1'b0; cur_len = 0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("init_rst_out", any_out(), 1'b0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    step();
    chk("init_tag_rdy", oPktTagRdy, 1'b1);

    chain[0] = 12'h010;
    run_pkt(0, 1, 1'b0, -1);
    run_pkt(0, 16, 1'b0, -1);
    chain[0] = 12'h020; chain[1] = 12'h035; chain[2] = 12'h007;
    run_pkt(2, 40, 1'b0, -1);
    run_pkt(2, 40, 1'b1, -1);
    rand_chain(2);
    run_pkt(2, 5, 1'b0, -1);
    rand_chain(0);
    run_pkt(0, 20, 1'b0, -1);
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(0, 4);
      rand_chain(len);
      n = $urandom_range(1, (len + 1) * 16 + 10);
      run_pkt(len, n, 1'($urandom_range(0, 1)), -1);
    end
    rand_chain(2);
    run_pkt(2, 40, 1'b0, 7);
    rand_chain(1);
    run_pkt(1, 23, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
